// File: rtl/tarea3_pkg.sv
// Shared definitions for the Tarea 3 vector-loading blocks:
// FSM state encoding, element width and default vector length.
package tarea3_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LO,
    WAIT_HI,
    WRITE,
    DONE
  } state_t;

  localparam int ELEM_W                = 10;
  localparam int DEFAULT_NUM_ELEMENTOS = 1024;

endpackage

// File: rtl/vector_write_assembler.sv
// Assembles pairs of UART bytes into 10-bit elements and writes a full
// vector into BRAM A or B, with abort, byte-gap timeout and range flagging.
module vector_write_assembler
  import tarea3_pkg::*;
#(
  parameter int NUM_ELEMENTOS  = DEFAULT_NUM_ELEMENTOS,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             begin_write,
  input  logic                             target_sel,
  input  logic [7:0]                       rx_data,
  input  logic                             rx_ready,
  output logic                             bram_we_a,
  output logic                             bram_we_b,
  output logic [$clog2(NUM_ELEMENTOS)-1:0] bram_addr,
  output logic [ELEM_W-1:0]                bram_din,
  output logic                             write_done,
  output logic                             load_abort,
  output logic                             busy,
  output logic                             range_err
);

  localparam int ADDR_W = $clog2(NUM_ELEMENTOS);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ELEMENTOS - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  state_t state, next_state;

  logic              sel_b;
  logic [7:0]        lo_byte;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ELEM_W-1:0] element;
  logic [TO_W-1:0]   to_cnt;

  logic start_load, take_lo, take_hi, advance, abort, finish;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // A falling begin_write wins over a coincident rx_ready, so that byte is dropped.
  always_comb begin
    next_state = state;
    start_load = 1'b0;
    take_lo    = 1'b0;
    take_hi    = 1'b0;
    advance    = 1'b0;
    abort      = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (begin_write) begin
          next_state = WAIT_LO;
          start_load = 1'b1;
        end
      end
      WAIT_LO: begin
        if (!begin_write) begin
          next_state = IDLE;
          abort      = 1'b1;
        end else if (rx_ready) begin
          next_state = WAIT_HI;
          take_lo    = 1'b1;
        end
      end
      WAIT_HI: begin
        if (!begin_write) begin
          next_state = IDLE;
          abort      = 1'b1;
        end else if (rx_ready) begin
          next_state = WRITE;
          take_hi    = 1'b1;
        end else if (to_cnt == TO_LAST) begin
          next_state = WAIT_LO;
        end
      end
      WRITE: begin
        if (!begin_write) begin
          next_state = IDLE;
          abort      = 1'b1;
        end else if (addr_cnt == LAST_ADDR) begin
          next_state = DONE;
          finish     = 1'b1;
        end else begin
          next_state = WAIT_LO;
          advance    = 1'b1;
        end
      end
      DONE: begin
        if (!begin_write) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_b      <= 1'b0;
      lo_byte    <= '0;
      addr_cnt   <= '0;
      element    <= '0;
      to_cnt     <= '0;
      range_err  <= 1'b0;
      write_done <= 1'b0;
      load_abort <= 1'b0;
    end else begin
      write_done <= finish;
      load_abort <= abort;
      if (start_load) begin
        sel_b     <= target_sel;
        addr_cnt  <= '0;
        range_err <= 1'b0;
      end
      if (take_lo) lo_byte <= rx_data;
      if (take_hi) begin
        element <= {rx_data[1:0], lo_byte};
        if (|rx_data[7:2]) range_err <= 1'b1;
      end
      if (advance) addr_cnt <= addr_cnt + 1'b1;
      // Restarts on every entry to WAIT_HI; a timeout discards the held low byte.
      if (state == WAIT_HI && next_state == WAIT_HI) to_cnt <= to_cnt + 1'b1;
      else                                           to_cnt <= '0;
    end
  end

  assign busy      = (state != IDLE);
  assign bram_we_a = (state == WRITE) && !sel_b;
  assign bram_we_b = (state == WRITE) && sel_b;
  assign bram_addr = addr_cnt;
  assign bram_din  = element;

endmodule

// File: tb/tb_vector_write_assembler.sv
// Self-checking bench for vector_write_assembler: table-driven loads with a
// write scoreboard, plus hand-written abort, timeout and reset sequences.
module tb_vector_write_assembler;
  import tarea3_pkg::*;

  localparam int N  = 4;
  localparam int TO = 50;
  localparam int AW = $clog2(N);

  logic              clk = 1'b0;
  logic              reset;
  logic              begin_write;
  logic              target_sel;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              bram_we_a;
  logic              bram_we_b;
  logic [AW-1:0]     bram_addr;
  logic [ELEM_W-1:0] bram_din;
  logic              write_done;
  logic              load_abort;
  logic              busy;
  logic              range_err;

  vector_write_assembler #(
    .NUM_ELEMENTOS (N),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .begin_write(begin_write),
    .target_sel (target_sel),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .bram_we_a  (bram_we_a),
    .bram_we_b  (bram_we_b),
    .bram_addr  (bram_addr),
    .bram_din   (bram_din),
    .write_done (write_done),
    .load_abort (load_abort),
    .busy       (busy),
    .range_err  (range_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              b;
    logic [AW-1:0]     addr;
    logic [ELEM_W-1:0] din;
  } wr_t;

  typedef struct {
    logic              sel;
    logic [7:0]        lo;
    logic [7:0]        hi;
    logic [AW-1:0]     addr;
    logic [ELEM_W-1:0] din;
    logic              rerr;
  } vec_t;

  wr_t  sb[$];
  vec_t vecs[8];

  int checks      = 0;
  int passed      = 0;
  int done_cycles = 0;
  int abort_cycles = 0;
  int we_b_cycles = 0;
  int done_before;
  int abort_before;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    else
      passed++;
  endtask

  // Every observed write must match the oldest pending expectation.
  always @(negedge clk) begin
    if (write_done) done_cycles++;
    if (load_abort) abort_cycles++;
    if (bram_we_b) we_b_cycles++;
    if (bram_we_a || bram_we_b) begin
      check("we_exclusive", 32'(bram_we_a & bram_we_b), 32'd0);
      check("write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        wr_t exp;
        exp = sb.pop_front();
        check("write_data", 32'({bram_we_b, bram_addr, bram_din}), 32'(exp));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(1);
  endtask

  task automatic start_load(input logic sel);
    target_sel  = sel;
    begin_write = 1'b1;
    tick(1);
    target_sel = ~sel;
  endtask

  task automatic apply_stimulus(input vec_t v, input int gap = 0);
    send_byte(v.lo);
    if (gap > 0) tick(gap);
    sb.push_back(wr_t'{b: v.sel, addr: v.addr, din: v.din});
    rx_data  = v.hi;
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    @(negedge clk);
    check("write_latency", 32'(bram_we_a | bram_we_b), 32'd1);
    tick(1);
    check("range_err", 32'(range_err), 32'(v.rerr));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_we"}, 32'({bram_we_a, bram_we_b}), 32'd0);
    check({tag, "_addr"}, 32'(bram_addr), 32'd0);
    check({tag, "_din"}, 32'(bram_din), 32'd0);
    check({tag, "_pulses"}, 32'({write_done, load_abort}), 32'd0);
    check({tag, "_range_err"}, 32'(range_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    begin_write = 1'b0;
    target_sel  = 1'b0;
    rx_data     = 8'h00;
    rx_ready    = 1'b0;
    tick(3);
    check_all_zero("reset");
    reset = 1'b0;
    tick(2);

    vecs[0] = '{1'b0, 8'h01, 8'h00, 2'd0, 10'h001, 1'b0};
    vecs[1] = '{1'b0, 8'hFF, 8'h03, 2'd1, 10'h3FF, 1'b0};
    vecs[2] = '{1'b0, 8'h10, 8'h02, 2'd2, 10'h210, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 8'h00, 2'd3, 10'h000, 1'b0};
    vecs[4] = '{1'b1, 8'h45, 8'h07, 2'd0, 10'h345, 1'b1};
    vecs[5] = '{1'b1, 8'hAA, 8'h01, 2'd1, 10'h1AA, 1'b1};
    vecs[6] = '{1'b1, 8'h0F, 8'h02, 2'd2, 10'h20F, 1'b1};
    vecs[7] = '{1'b1, 8'h80, 8'h00, 2'd3, 10'h080, 1'b1};

    for (int l = 0; l < 2; l++) begin
      $display("[TB] table load %0d", l);
      start_load(vecs[4*l].sel);
      for (int i = 0; i < 4; i++) apply_stimulus(vecs[4*l+i]);
      tick(2);
      check("done_pulse", 32'(done_cycles), 32'(l + 1));
      check("busy_in_done", 32'(busy), 32'd1);
      if (l == 0) check("we_b_never", 32'(we_b_cycles), 32'd0);
      // Held request with traffic must neither restart nor write.
      for (int k = 0; k < 3; k++) send_byte(8'h5A);
      tick(10);
      check("held_no_restart", 32'(done_cycles), 32'(l + 1));
      check("held_busy", 32'(busy), 32'd1);
      begin_write = 1'b0;
      tick(2);
      check("idle_after_release", 32'(busy), 32'd0);
    end
    check("range_err_sticky", 32'(range_err), 32'd1);
    check("no_abort_yet", 32'(abort_cycles), 32'd0);

    $display("[TB] abort after two elements");
    done_before  = done_cycles;
    abort_before = abort_cycles;
    start_load(1'b0);
    check("range_err_cleared", 32'(range_err), 32'd0);
    apply_stimulus('{1'b0, 8'h11, 8'h00, 2'd0, 10'h011, 1'b0});
    apply_stimulus('{1'b0, 8'h22, 8'h01, 2'd1, 10'h122, 1'b0});
    begin_write = 1'b0;
    tick(3);
    check("abort_pulse", 32'(abort_cycles), 32'(abort_before + 1));
    check("abort_no_done", 32'(done_cycles), 32'(done_before));
    check("abort_idle", 32'(busy), 32'd0);
    start_load(1'b0);
    apply_stimulus('{1'b0, 8'h33, 8'h00, 2'd0, 10'h033, 1'b0});

    $display("[TB] drop coinciding with high byte");
    send_byte(8'h44);
    rx_data     = 8'h01;
    rx_ready    = 1'b1;
    begin_write = 1'b0;
    tick(1);
    rx_ready = 1'b0;
    tick(3);
    check("coincident_abort", 32'(abort_cycles), 32'(abort_before + 2));
    check("coincident_idle", 32'(busy), 32'd0);

    $display("[TB] drop during WRITE");
    start_load(1'b1);
    send_byte(8'h9C);
    sb.push_back(wr_t'{b: 1'b1, addr: 2'd0, din: 10'h29C});
    rx_data  = 8'h02;
    rx_ready = 1'b1;
    tick(1);
    rx_ready    = 1'b0;
    begin_write = 1'b0;
    tick(3);
    check("write_then_abort", 32'(abort_cycles), 32'(abort_before + 3));
    check("write_completed", 32'(sb.size()), 32'd0);
    check("abort_never_done", 32'(done_cycles), 32'(done_before));

    $display("[TB] byte-gap timeout");
    done_before = done_cycles;
    start_load(1'b0);
    apply_stimulus('{1'b0, 8'h05, 8'h00, 2'd0, 10'h005, 1'b0});
    send_byte(8'h77);
    tick(60);
    apply_stimulus('{1'b0, 8'h33, 8'h01, 2'd1, 10'h133, 1'b0});
    apply_stimulus('{1'b0, 8'h66, 8'h02, 2'd2, 10'h266, 1'b0}, 30);
    apply_stimulus('{1'b0, 8'hC3, 8'h03, 2'd3, 10'h3C3, 1'b0});
    tick(2);
    check("timeout_load_done", 32'(done_cycles), 32'(done_before + 1));
    begin_write = 1'b0;
    tick(2);

    $display("[TB] reset during WAIT_HI");
    done_before  = done_cycles;
    abort_before = abort_cycles;
    start_load(1'b1);
    apply_stimulus('{1'b1, 8'h12, 8'h04, 2'd0, 10'h012, 1'b1});
    send_byte(8'hAB);
    check("pre_reset_addr", 32'(bram_addr), 32'd1);
    #2 reset = 1'b1;
    begin_write = 1'b0;
    #1;
    check_all_zero("async_reset");
    tick(3);
    reset = 1'b0;
    tick(3);
    check("reset_no_done", 32'(done_cycles), 32'(done_before));
    check("reset_no_abort", 32'(abort_cycles), 32'(abort_before));
    check("reset_idle", 32'(busy), 32'd0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
